// File: rtl/cpu_player_if.sv
// Playfield-facing signal bundle of the computer opponent.
// master is the player side; slave is the playfield/switch side.
interface cpu_player_if;
  logic       enable;
  logic [8:0] difficulty;
  logic       game_over;
  logic       press;
  logic [7:0] press_count;
  logic [9:0] lfsr_q;

  modport master (
    input  enable,
    input  difficulty,
    input  game_over,
    output press,
    output press_count,
    output lfsr_q
  );

  modport slave (
    output enable,
    output difficulty,
    output game_over,
    input  press,
    input  press_count,
    input  lfsr_q
  );
endinterface

// File: rtl/cpu_player.sv
// Computer opponent for tug-of-war: LFSR-vs-difficulty presses with a forced
// cooldown, halting for good once the playfield reports a winner.
module cpu_player #(
  parameter int unsigned COOLDOWN = 4
) (
  input logic          clk,
  input logic          reset,
  cpu_player_if.master bus
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StArmed = 3'd1;
  localparam logic [2:0] StPress = 3'd2;
  localparam logic [2:0] StCool  = 3'd3;
  localparam logic [2:0] StHalt  = 3'd4;

  localparam logic [7:0] CoolLoad = 8'(COOLDOWN - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] press_count_q, press_count_d;
  logic [9:0] lfsr_q, lfsr_d;
  logic       fire;

  // Unsigned compare on the pre-advance LFSR value; 0 never fires.
  assign fire = {1'b0, bus.difficulty} > lfsr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.game_over) begin
      state_d = StHalt;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.enable) state_d = StArmed;
        end
        StArmed: begin
          if (!bus.enable) state_d = StIdle;
          else if (fire)   state_d = StPress;
        end
        StPress: begin
          state_d = StCool;
          cnt_d   = CoolLoad;
        end
        StCool: begin
          if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
          else               state_d = bus.enable ? StArmed : StIdle;
        end
        StHalt: state_d = StHalt;
        default: state_d = StIdle;
      endcase
    end
  end

  // PRESS always exits after one cycle, so any move into it is an entry.
  assign press_count_d = (state_d == StPress) ? press_count_q + 8'd1 : press_count_q;

  assign lfsr_d = (state_q == StHalt) ? lfsr_q : {lfsr_q[8:0], ~(lfsr_q[9] ^ lfsr_q[6])};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= 8'd0;
      press_count_q <= 8'd0;
      lfsr_q        <= 10'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      press_count_q <= press_count_d;
      lfsr_q        <= lfsr_d;
    end
  end

  assign bus.press       = (state_q == StPress);
  assign bus.press_count = press_count_q;
  assign bus.lfsr_q      = lfsr_q;

endmodule

// File: tb/tb_cpu_player.sv
// Self-checking bench for cpu_player: expected press pulses are queued when
// stimulus is applied and matched against observed pulses.
module tb_cpu_player;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_t[$];
  int   exp_cnt[$];

  cpu_player_if bus ();

  cpu_player #(.COOLDOWN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] lfsr_next(input logic [9:0] q);
    return {q[8:0], ~(q[9] ^ q[6])};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves reset asserted for two edges; the next edge is the first live one.
  task automatic do_reset();
    reset          = 1'b0;
    bus.enable     = 1'b0;
    bus.game_over  = 1'b0;
    bus.difficulty = 9'd511;
    tick();
    tick();
    reset = 1'b1;
    exp_t.delete();
    exp_cnt.delete();
  endtask

  task automatic test_reset();
    logic [9:0] seq[4];
    seq = '{10'd1, 10'd3, 10'd7, 10'd15};
    reset          = 1'b0;
    bus.enable     = 1'b1;
    bus.game_over  = 1'b0;
    bus.difficulty = 9'd511;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (bus.press !== 1'b0 || bus.press_count !== 8'd0 || bus.lfsr_q !== 10'd0) begin
        n_fail++;
        $display("FAIL reset_hold: press=%0b count=%0d lfsr=%0d, required 0/0/0",
                 bus.press, bus.press_count, bus.lfsr_q);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus.lfsr_q !== seq[i]) begin
        n_fail++;
        $display("FAIL reset_lfsr_seq[%0d]: got %0d, required %0d", i, bus.lfsr_q, seq[i]);
      end
    end
  endtask

  task automatic test_diff_zero();
    int seen = 0;
    do_reset();
    bus.difficulty = 9'd0;
    bus.enable     = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.press === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0 || bus.press_count !== 8'd0) begin
      n_fail++;
      $display("FAIL diff_zero: pulses=%0d count=%0d, required 0/0", seen, bus.press_count);
    end
  endtask

  task automatic test_max_rate();
    do_reset();
    tick();
    bus.enable = 1'b1;
    exp_t.push_back(2);  exp_cnt.push_back(1);
    exp_t.push_back(8);  exp_cnt.push_back(2);
    for (int t = 1; t <= 13; t++) begin
      tick();
      if (bus.press === 1'b1) begin
        n_checks++;
        if (exp_t.size() == 0) begin
          n_fail++;
          $display("FAIL max_rate_extra: press at t=%0d, required none", t);
        end else begin
          int et, ec;
          et = exp_t.pop_front();
          ec = exp_cnt.pop_front();
          if (t != et || int'(bus.press_count) != ec) begin
            n_fail++;
            $display("FAIL max_rate_pulse: t=%0d count=%0d, required t=%0d count=%0d",
                     t, bus.press_count, et, ec);
          end
        end
      end
    end
    n_checks++;
    if (exp_t.size() != 0) begin
      n_fail++;
      $display("FAIL max_rate_missing: %0d pulses outstanding, required 0", exp_t.size());
    end
  endtask

  task automatic test_game_over();
    do_reset();
    tick();
    bus.enable = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.press !== 1'b1) begin
      n_fail++;
      $display("FAIL go_first_press: press=%0b, required 1", bus.press);
    end
    tick();
    bus.game_over = 1'b1;
    tick();
    n_checks++;
    if (bus.lfsr_q !== 10'd31) begin
      n_fail++;
      $display("FAIL go_halt_lfsr: got %0d, required 31", bus.lfsr_q);
    end
    bus.game_over = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_checks++;
      if (bus.press !== 1'b0 || bus.lfsr_q !== 10'd31 || bus.press_count !== 8'd1) begin
        n_fail++;
        $display("FAIL go_halted[%0d]: press=%0b lfsr=%0d count=%0d, required 0/31/1",
                 i, bus.press, bus.lfsr_q, bus.press_count);
      end
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (bus.lfsr_q !== 10'd0 || bus.press_count !== 8'd0) begin
      n_fail++;
      $display("FAIL go_reset: lfsr=%0d count=%0d, required 0/0", bus.lfsr_q, bus.press_count);
    end
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.press !== 1'b1 || bus.press_count !== 8'd1) begin
      n_fail++;
      $display("FAIL go_recover: press=%0b count=%0d, required 1/1", bus.press, bus.press_count);
    end
  endtask

  task automatic test_enable_drop();
    logic [9:0] m;
    int         t;
    bit         found;
    do_reset();
    tick();
    m = 10'd1;
    t = 0;
    bus.enable = 1'b1;
    exp_t.push_back(2);
    exp_cnt.push_back(1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      t = i;
      m = lfsr_next(m);
      n_checks++;
      if (bus.lfsr_q !== m) begin
        n_fail++;
        $display("FAIL drop_lfsr t=%0d: got %0d, required %0d", t, bus.lfsr_q, m);
      end
      if (t == 3) bus.enable = 1'b0;
      if (bus.press === 1'b1) begin
        n_checks++;
        if (exp_t.size() == 0) begin
          n_fail++;
          $display("FAIL drop_extra: press at t=%0d, required none", t);
        end else begin
          int et, ec;
          et = exp_t.pop_front();
          ec = exp_cnt.pop_front();
          if (t != et || int'(bus.press_count) != ec) begin
            n_fail++;
            $display("FAIL drop_pulse: t=%0d count=%0d, required t=%0d count=%0d",
                     t, bus.press_count, et, ec);
          end
        end
      end
    end
    n_checks++;
    if (exp_t.size() != 0 || bus.press_count !== 8'd1) begin
      n_fail++;
      $display("FAIL drop_idle: outstanding=%0d count=%0d, required 0/1",
               exp_t.size(), bus.press_count);
    end
    // Re-raise enable only when the model says the ARMED compare will fire.
    found = 1'b0;
    for (int i = 0; i < 1100 && !found; i++) begin
      if (lfsr_next(m) < 10'd511) begin
        found = 1'b1;
        bus.enable = 1'b1;
      end else begin
        tick();
        m = lfsr_next(m);
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL drop_search: no firing window found, required one");
    end else begin
      tick();
      n_checks++;
      if (bus.press !== 1'b0) begin
        n_fail++;
        $display("FAIL drop_armed: press=%0b, required 0", bus.press);
      end
      tick();
      n_checks++;
      if (bus.press !== 1'b1 || bus.press_count !== 8'd2) begin
        n_fail++;
        $display("FAIL drop_rearm_press: press=%0b count=%0d, required 1/2",
                 bus.press, bus.press_count);
      end
    end
  endtask

  task automatic test_reset_in_press();
    do_reset();
    tick();
    bus.enable = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.press !== 1'b1) begin
      n_fail++;
      $display("FAIL rip_press: press=%0b, required 1", bus.press);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (bus.press !== 1'b0 || bus.press_count !== 8'd0 || bus.lfsr_q !== 10'd0) begin
      n_fail++;
      $display("FAIL rip_cleared: press=%0b count=%0d lfsr=%0d, required 0/0/0",
               bus.press, bus.press_count, bus.lfsr_q);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (bus.press !== 1'b0) begin
      n_fail++;
      $display("FAIL rip_idle_armed: press=%0b, required 0", bus.press);
    end
    tick();
    n_checks++;
    if (bus.press !== 1'b1 || bus.press_count !== 8'd1) begin
      n_fail++;
      $display("FAIL rip_restart: press=%0b count=%0d, required 1/1", bus.press, bus.press_count);
    end
  endtask

  initial begin
    test_reset();
    test_diff_zero();
    test_max_rate();
    test_game_over();
    test_enable_drop();
    test_reset_in_press();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_player.md
# cpu_player

Computer opponent for the player-vs-computer tug-of-war game. It generates the button presses that the `lights` playfield receives on its computer-side input (`R`). A 10-bit LFSR produces pseudo-random values, and each value is compared against a switch-set difficulty. Each press is a clean one-cycle pulse followed by an enforced cooldown, and the block halts permanently once the playfield reports a winner.

## Interface
- `COOLDOWN`, default 4: cycles of forced idle after each press; legal range 1–255.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-low (`reset`=0 resets on the next rising `clk`).
- `enable` in 1: computer is allowed to play; level-sensitive.
- `difficulty` in 9: press threshold (from switches `SW[8:0]`); 0 = never press, 511 = most aggressive.
- `game_over` in 1: `wL | wR` from the playfield; level-sensitive.
- `press` out 1: one-cycle press pulse, drives the playfield `R`.
- `press_count` out 8: number of presses issued, wraps modulo 256.
- `lfsr_q` out 10: current LFSR value (debug/observability).

## Operation
- LFSR:
  - 10-bit, `next = {q[8:0], ~(q[9] ^ q[6])}` (XNOR, maximal length 1023; the lockup state is all-ones).
  - Reset value is 0.
  - Advances every cycle in all states except HALT, where it freezes.
  - From reset the sequence is 0, 1, 3, 7, 15, 31, 63, 127, 255, 511, 1022, …
- Fire condition: `{1'b0, difficulty} > lfsr_q`, an unsigned 10-bit compare on the current (pre-advance) `lfsr_q`.
- States: IDLE, ARMED, PRESS, COOLDOWN, HALT.
- Transitions are evaluated at each rising `clk`. Priority order is reset, then `game_over`, then `enable`, then fire.
  - Any state with `game_over`=1 → HALT.
  - IDLE: `enable`=1 → ARMED; otherwise stay.
  - ARMED: `enable`=0 → IDLE; fire → PRESS; otherwise stay.
  - PRESS: → COOLDOWN, and the counter loads `COOLDOWN-1`. This transition is unconditional (except for `game_over`), so the pulse is always exactly one cycle wide.
  - COOLDOWN: counter > 0 → decrement and stay; counter = 0 → ARMED if `enable`=1, else IDLE.
  - HALT: stay until reset; `enable` is ignored.
- `press` is registered and equals 1 exactly while the state is PRESS.
- `press_count` increments on entry to PRESS; 255 + 1 = 0.
- Cooldown counter width is 8 bits.

## Timing
- Reset values: state IDLE, `press`=0, `press_count`=0, `lfsr_q`=0, cooldown counter 0.
- Latency:
  - `enable` rises and is sampled at edge k → ARMED from edge k.
  - Fire evaluated at edge k+1 → `press`=1 during cycle k+1..k+2.
- Minimum press-to-press spacing is `COOLDOWN`+2 cycles (PRESS, `COOLDOWN` cycles of COOLDOWN, at least one ARMED). With `COOLDOWN`=4 the period is 6 cycles when fire is true every ARMED cycle.
- `game_over` asserted in the same cycle as PRESS: `press` still ends after that cycle, the next state is HALT, and no further pulses occur.
- `enable` dropping mid-cooldown: the cooldown still completes, then the block goes to IDLE; no press is issued.
- Reset mid-PRESS or mid-COOLDOWN: at that edge `press`=0, state IDLE, and the counter and LFSR are cleared.
- `difficulty` changes take effect on the next ARMED compare; no latching.

## Test plan
- Reset hold, with `reset`=0 for 2 cycles and `enable`=1:
  - `press`=0, `press_count`=0, `lfsr_q`=0 throughout.
  - After release, `lfsr_q` steps 1, 3, 7, 15 on successive cycles.
- `difficulty`=0, `enable`=1, 200 cycles → `press` never asserts and `press_count` stays 0.
- `difficulty`=511, `COOLDOWN`=4, `enable` raised 1 cycle after reset release:
  - First `press` pulse lands 2 cycles later.
  - The second pulse follows exactly 6 cycles after the first.
  - Each pulse is exactly 1 cycle wide, and `press_count` reads 1 then 2.
- `game_over`=1 while in COOLDOWN (`difficulty`=511):
  - HALT on the next edge.
  - `lfsr_q` frozen.
  - No `press` for 50 cycles even with `enable`=1 and `game_over` dropped.
  - Only `reset`=0 recovers.
- `enable` dropped during COOLDOWN → no further pulses. Re-raising `enable` → ARMED on the next edge and a press on the following edge (`difficulty`=511).
- `reset`=0 asserted in the PRESS cycle → `press`=0 and `press_count`=0 on the next cycle, and the state returns to IDLE.
